// File: rtl/result_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : result_uart_tx
//  Purpose  : Captures a 32-bit result word on a valid/ready handshake and
//             sends it as 8 uppercase ASCII hex digits (MSB nibble first)
//             followed by CR LF over a UART 8N1 line.
//  Revision : 1.0  initial release
// ============================================================================
module result_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        rst,            // synchronous, active-low
    input  logic        result_valid,
    input  logic [31:0] result,
    output logic        ready,
    output logic        busy,
    output logic        tx,
    output logic        overrun
);

    localparam logic [15:0] c_BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  c_LAST_BYTE = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_hold;
    logic [3:0]  r_byte_idx;
    logic [2:0]  r_bit_idx;
    logic [15:0] r_baud_cnt;
    logic        r_tx;
    logic        r_ready;
    logic        r_busy;
    logic        r_overrun;

    logic [4:0]  w_nib_lsb;
    logic [3:0]  w_nibble;
    logic [7:0]  w_hex;
    logic [7:0]  w_byte;
    logic        w_bit_end;

    // Select the character for the current byte slot: hex digit, CR or LF
    always_comb begin
        w_nib_lsb = 5'd28 - {r_byte_idx[2:0], 2'b00};
        w_nibble  = r_hold[w_nib_lsb +: 4];
        // 'A' - 10 = 8'h37, so letters come out as 8'h37 + nibble
        w_hex     = (w_nibble < 4'd10) ? (8'h30 + {4'h0, w_nibble})
                                       : (8'h37 + {4'h0, w_nibble});
        case (r_byte_idx)
            4'd8:    w_byte = 8'h0D;
            4'd9:    w_byte = 8'h0A;
            default: w_byte = w_hex;
        endcase
        w_bit_end = (r_baud_cnt == c_BAUD_LAST);
    end

    // Frame sequencer: handshake, start/data/stop bit timing and sticky overrun
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_hold     <= 32'h0;
            r_byte_idx <= 4'd0;
            r_bit_idx  <= 3'd0;
            r_baud_cnt <= 16'd0;
            r_tx       <= 1'b1;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            // A word offered while a frame is running is dropped and flagged
            if (result_valid && !r_ready) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (result_valid && r_ready) begin
                        r_hold     <= result;
                        r_state    <= S_START;
                        r_tx       <= 1'b0;
                        r_ready    <= 1'b0;
                        r_busy     <= 1'b1;
                        r_byte_idx <= 4'd0;
                        r_bit_idx  <= 3'd0;
                        r_baud_cnt <= 16'd0;
                    end
                end

                S_START: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= 16'd0;
                        r_bit_idx  <= 3'd0;
                        r_state    <= S_DATA;
                        r_tx       <= w_byte[0];
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 16'd1;
                    end
                end

                S_DATA: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= 16'd0;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= w_byte[r_bit_idx + 3'd1];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 16'd1;
                    end
                end

                S_STOP: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= 16'd0;
                        if (r_byte_idx < c_LAST_BYTE) begin
                            // next start bit follows the stop bit directly
                            r_byte_idx <= r_byte_idx + 4'd1;
                            r_state    <= S_START;
                            r_tx       <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 16'd1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ready   = r_ready;
    assign busy    = r_busy;
    assign tx      = r_tx;
    assign overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_result_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_result_uart_tx
//  Purpose  : Self-checking bench for result_uart_tx; a UART receiver model
//             decodes the serial line and compares each byte with a queue of
//             expected characters pushed when the word is offered.
//  Revision : 1.0  initial release
// ============================================================================
module tb_result_uart_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        v1, v2;
    logic [31:0] d1, d2;
    logic        rdy1, bsy1, tx1, ov1;
    logic        rdy2, bsy2, tx2, ov2;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  q1[$];
    logic [7:0]  q2[$];
    bit          mon_en = 1'b1;

    logic [7:0]  rx1_b, rx2_b;
    logic        rx1_s, rx2_s;

    always #5 clk = ~clk;

    result_uart_tx #(.CLKS_PER_BIT(16)) dut (
        .clk(clk), .rst(rst), .result_valid(v1), .result(d1),
        .ready(rdy1), .busy(bsy1), .tx(tx1), .overrun(ov1)
    );

    result_uart_tx #(.CLKS_PER_BIT(2)) dut2 (
        .clk(clk), .rst(rst), .result_valid(v2), .result(d2),
        .ready(rdy2), .busy(bsy2), .tx(tx2), .overrun(ov2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return 8'h41 + {4'h0, n - 4'd10};
    endfunction

    task automatic push_frame(input int sel, input logic [31:0] w);
        logic [7:0] c;
        for (int i = 0; i < 10; i++) begin
            if (i < 8)       c = hexc(w[31-4*i -: 4]);
            else if (i == 8) c = 8'h0D;
            else             c = 8'h0A;
            if (sel == 1) q1.push_back(c);
            else          q2.push_back(c);
        end
    endtask

    // Sample one 8N1 character; called at the first negedge showing the start bit
    task automatic rx_byte(input int sel, input int cpb, output logic [7:0] b, output logic s);
        repeat (cpb / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (cpb) @(negedge clk);
            b[i] = (sel == 1) ? tx1 : tx2;
        end
        repeat (cpb) @(negedge clk);
        s = (sel == 1) ? tx1 : tx2;
    endtask

    // Receiver for the 16-clocks-per-bit instance
    always begin
        @(negedge clk);
        if (rst === 1'b1 && tx1 === 1'b0) begin
            rx_byte(1, 16, rx1_b, rx1_s);
            if (mon_en) begin
                check("stop1", {31'h0, rx1_s}, 32'h1);
                n_checks++;
                assert (q1.size() != 0) else begin
                    n_errors++;
                    $error("FAIL byte1: observed=%h expected=none", rx1_b);
                end
                if (q1.size() != 0) check("byte1", {24'h0, rx1_b}, {24'h0, q1.pop_front()});
            end
        end
    end

    // Receiver for the 2-clocks-per-bit instance
    always begin
        @(negedge clk);
        if (rst === 1'b1 && tx2 === 1'b0) begin
            rx_byte(2, 2, rx2_b, rx2_s);
            check("stop2", {31'h0, rx2_s}, 32'h1);
            n_checks++;
            assert (q2.size() != 0) else begin
                n_errors++;
                $error("FAIL byte2: observed=%h expected=none", rx2_b);
            end
            if (q2.size() != 0) check("byte2", {24'h0, rx2_b}, {24'h0, q2.pop_front()});
        end
    end

    // Offer a word on dut; returns at the first negedge after the accept edge
    task automatic accept1(input logic [31:0] w, input bit keep);
        push_frame(1, w);
        @(negedge clk);
        check("ready_before", {31'h0, rdy1}, 32'h1);
        d1 = w;
        v1 = 1'b1;
        @(negedge clk);
        if (!keep) v1 = 1'b0;
        check("tx_start", {31'h0, tx1}, 32'h0);
        check("busy_on", {31'h0, bsy1}, 32'h1);
    endtask

    // Count edges after the accept edge until ready is seen high
    task automatic wait_ready1(input int k0, output int k);
        k = k0;
        while (rdy1 !== 1'b1 && k < 5000) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        int         k, k1, k2;
        logic [7:0] bd;
        logic       eb;

        rst = 1'b0; v1 = 1'b0; d1 = 32'h0; v2 = 1'b0; d2 = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_tx", {31'h0, tx1}, 32'h1);
        check("rst_ready", {31'h0, rdy1}, 32'h1);
        check("rst_busy", {31'h0, bsy1}, 32'h0);
        check("rst_overrun", {31'h0, ov1}, 32'h0);
        check("rst_tx2", {31'h0, tx2}, 32'h1);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single word, full-frame length
        accept1(32'h0000002A, 1'b0);
        wait_ready1(0, k);
        check("len_2A", k, 32'd1600);
        check("busy_off", {31'h0, bsy1}, 32'h0);
        check("ov_2A", {31'h0, ov1}, 32'h0);
        repeat (5) @(negedge clk);
        check("q_2A", q1.size(), 32'd0);

        // Bit-level waveform of the first character of DEADBEEF
        bd = 8'h44;
        accept1(32'hDEADBEEF, 1'b0);
        for (int c = 0; c < 160; c++) begin
            if (c < 16)       eb = 1'b0;
            else if (c < 144) eb = bd[(c / 16) - 1];
            else              eb = 1'b1;
            check("bitwave", {31'h0, tx1}, {31'h0, eb});
            @(negedge clk);
        end
        wait_ready1(160, k);
        check("len_DEAD", k, 32'd1600);
        repeat (5) @(negedge clk);
        check("q_DEAD", q1.size(), 32'd0);

        // Overrun during a frame leaves the frame intact
        accept1(32'h12345678, 1'b0);
        repeat (198) @(negedge clk);
        check("ov_pre", {31'h0, ov1}, 32'h0);
        d1 = 32'hFFFFFFFF;
        v1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0;
        check("ov_set", {31'h0, ov1}, 32'h1);
        wait_ready1(199, k);
        check("len_1234", k, 32'd1600);
        repeat (300) @(negedge clk);
        check("idle_tx", {31'h0, tx1}, 32'h1);
        check("idle_ready", {31'h0, rdy1}, 32'h1);
        check("ov_sticky", {31'h0, ov1}, 32'h1);
        check("q_1234", q1.size(), 32'd0);

        // Reset in the middle of a frame
        accept1(32'hCAFEF00D, 1'b0);
        repeat (499) @(negedge clk);
        mon_en = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("mrst_tx", {31'h0, tx1}, 32'h1);
        check("mrst_ready", {31'h0, rdy1}, 32'h1);
        check("mrst_busy", {31'h0, bsy1}, 32'h0);
        check("mrst_ov", {31'h0, ov1}, 32'h0);
        q1.delete();
        repeat (250) @(negedge clk);
        mon_en = 1'b1;
        accept1(32'h00000000, 1'b0);
        wait_ready1(0, k);
        check("len_0000", k, 32'd1600);
        repeat (5) @(negedge clk);
        check("q_0000", q1.size(), 32'd0);

        // Back-to-back with valid held high
        accept1(32'h00000001, 1'b1);
        repeat (99) @(negedge clk);
        d1 = 32'h0000000F;
        push_frame(1, 32'h0000000F);
        @(negedge clk);
        check("ov_b2b", {31'h0, ov1}, 32'h1);
        wait_ready1(100, k1);
        check("len_b2b1", k1, 32'd1600);
        @(negedge clk);
        check("b2b_ready", {31'h0, rdy1}, 32'h0);
        check("b2b_tx", {31'h0, tx1}, 32'h0);
        v1 = 1'b0;
        wait_ready1(0, k2);
        check("len_b2b2", k2, 32'd1600);
        check("len_b2b_total", k1 + k2, 32'd3200);
        repeat (5) @(negedge clk);
        check("q_b2b", q1.size(), 32'd0);

        // Minimum bit period on the second instance
        push_frame(2, 32'hA5A5A5A5);
        @(negedge clk);
        check("ready2_before", {31'h0, rdy2}, 32'h1);
        d2 = 32'hA5A5A5A5;
        v2 = 1'b1;
        @(negedge clk);
        v2 = 1'b0;
        check("tx2_start", {31'h0, tx2}, 32'h0);
        k = 0;
        while (rdy2 !== 1'b1 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check("len_A5", k, 32'd200);
        check("ov2", {31'h0, ov2}, 32'h0);
        repeat (10) @(negedge clk);
        check("q_A5", q2.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
